door_timer: RTL and testbench

Parametrised door-open timer for the elevator controller. Watches the 2-bit door state and counts consecutive clock cycles with the doors fully open. Raises a warning (nudge) and then a timeout so the door controller can force closing. A limited number of passenger hold requests (door-open button / obstruction) restart the count; once the hold budget is spent, further holds are ignored.

---
 rtl/door_timer.sv | 118 +++++++++++
 tb/tb_door_timer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/door_timer.sv
// Door-open timer: counts open cycles, raises nudge then timeout, and lets a bounded number of holds restart the count.
// Every output is registered or decoded from registered state, so there is one cycle from input to output and no backpressure path.
module door_timer #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int NUDGE_CYCLES   = 800,
  parameter int MAX_HOLDS      = 3,
  parameter int HOLD_W         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       estado,
  input  logic             hold,
  output logic             timeout,
  output logic             timeout_pulse,
  output logic             nudge,
  output logic             holds_exhausted,
  output logic [CNT_W-1:0] elapsed
);

  localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  NUDGE_V   = CNT_W'(NUDGE_CYCLES);
  localparam logic [HOLD_W-1:0] MAXH_V    = HOLD_W'(MAX_HOLDS);
  localparam logic [1:0]        DOOR_OPEN = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  elapsed_q, elapsed_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              pulse_q, pulse_d;
  logic              exhausted_q;
  logic              is_open;
  logic              hold_ok;

  assign is_open = (estado == DOOR_OPEN);
  assign hold_ok = hold && (hold_cnt_q < MAXH_V);

  always_comb begin
    state_d    = state_q;
    elapsed_d  = elapsed_q;
    hold_cnt_d = hold_cnt_q;
    pulse_d    = 1'b0;
    case (state_q)
      IDLE: begin
        elapsed_d  = '0;
        hold_cnt_d = '0;
        if (is_open) begin
          state_d   = COUNT;
          elapsed_d = CNT_W'(1);
        end
      end
      COUNT: begin
        if (!is_open) begin
          state_d    = IDLE;
          elapsed_d  = '0;
          hold_cnt_d = '0;
        end else if (hold_ok) begin
          elapsed_d  = CNT_W'(1);
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (elapsed_q >= TIMEOUT_V - 1'b1) begin
          // Saturating compare also covers TIMEOUT_CYCLES=1, where elapsed is already at the limit.
          state_d   = EXPIRED;
          elapsed_d = TIMEOUT_V;
          pulse_d   = 1'b1;
        end else begin
          elapsed_d = elapsed_q + 1'b1;
        end
      end
      EXPIRED: begin
        if (!is_open) begin
          state_d    = IDLE;
          elapsed_d  = '0;
          hold_cnt_d = '0;
        end else if (hold_ok) begin
          state_d    = COUNT;
          elapsed_d  = CNT_W'(1);
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          elapsed_d = TIMEOUT_V;
        end
      end
      default: begin
        state_d    = IDLE;
        elapsed_d  = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elapsed_q   <= '0;
      hold_cnt_q  <= '0;
      pulse_q     <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      hold_cnt_q  <= hold_cnt_d;
      pulse_q     <= pulse_d;
      // Registered separately so it stays low in reset even when MAX_HOLDS is 0.
      exhausted_q <= (hold_cnt_d == MAXH_V);
    end
  end

  assign elapsed         = elapsed_q;
  assign timeout         = (state_q == EXPIRED);
  assign timeout_pulse   = pulse_q;
  assign nudge           = ((state_q == COUNT) && (elapsed_q >= NUDGE_V)) || (state_q == EXPIRED);
  assign holds_exhausted = exhausted_q;

endmodule

// File: tb/tb_door_timer.sv
// Scoreboard bench for door_timer with TIMEOUT_CYCLES=10, NUDGE_CYCLES=7, MAX_HOLDS=2, CNT_W=8.
module tb_door_timer;

  logic       clk;
  logic       rst;
  logic [1:0] estado;
  logic       hold;
  logic       timeout;
  logic       timeout_pulse;
  logic       nudge;
  logic       holds_exhausted;
  logic [7:0] elapsed;

  typedef struct {
    logic [7:0] el;
    logic       to;
    logic       tp;
    logic       nd;
    logic       he;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   s2_el[18] = '{1, 2, 3, 4, 1, 2, 3, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10};

  door_timer #(
    .CNT_W(8), .TIMEOUT_CYCLES(10), .NUDGE_CYCLES(7), .MAX_HOLDS(2), .HOLD_W(2)
  ) dut (
    .clk(clk), .rst(rst), .estado(estado), .hold(hold),
    .timeout(timeout), .timeout_pulse(timeout_pulse), .nudge(nudge),
    .holds_exhausted(holds_exhausted), .elapsed(elapsed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic step(input logic r, input logic [1:0] e, input logic h,
                      input int el, input logic to, input logic tp,
                      input logic nd, input logic he);
    exp_t x;
    @(negedge clk);
    rst    = r;
    estado = e;
    hold   = h;
    @(posedge clk);
    x.el = 8'(el);
    x.to = to;
    x.tp = tp;
    x.nd = nd;
    x.he = he;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("elapsed", int'(elapsed), int'(x.el));
      chk("timeout", int'(timeout), int'(x.to));
      chk("timeout_pulse", int'(timeout_pulse), int'(x.tp));
      chk("nudge", int'(nudge), int'(x.nd));
      chk("holds_exhausted", int'(holds_exhausted), int'(x.he));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    estado = 2'b00;
    hold   = 1'b0;

    // Reset state, including reset overriding an open door.
    step(1, 2'b00, 0, 0, 0, 0, 0, 0);
    step(1, 2'b01, 1, 0, 0, 0, 0, 0);

    // 1: plain count to timeout, then saturate.
    for (int k = 1; k <= 12; k++)
      step(0, 2'b01, 0, (k > 10) ? 10 : k, k >= 10, k == 10, k >= 7, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    // 2: holds at edges 5 and 8 accepted, edge 11 ignored, timeout after edge 17.
    for (int k = 1; k <= 18; k++)
      step(0, 2'b01, (k == 5) || (k == 8) || (k == 11), s2_el[k-1],
           k >= 17, k == 17, s2_el[k-1] >= 7, k >= 8);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    // 3: door starts closing before timeout.
    for (int k = 1; k <= 9; k++)
      step(0, 2'b01, 0, k, 0, 0, k >= 7, 0);
    step(0, 2'b11, 0, 0, 0, 0, 0, 0);

    // 4: hold out of EXPIRED, re-expire, spend the budget, then an ignored hold.
    for (int k = 1; k <= 10; k++)
      step(0, 2'b01, 0, k, k == 10, k == 10, k >= 7, 0);
    step(0, 2'b01, 0, 10, 1, 0, 1, 0);
    step(0, 2'b01, 1, 1, 0, 0, 0, 0);
    for (int k = 2; k <= 10; k++)
      step(0, 2'b01, 0, k, k == 10, k == 10, k >= 7, 0);
    step(0, 2'b01, 1, 1, 0, 0, 0, 1);
    step(0, 2'b01, 1, 2, 0, 0, 0, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    // 5: reset mid-count, then restart from 1.
    for (int k = 1; k <= 6; k++)
      step(0, 2'b01, 0, k, 0, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0, 0, 0, 0);
    step(0, 2'b01, 0, 1, 0, 0, 0, 0);
    step(0, 2'b01, 0, 2, 0, 0, 0, 0);
    step(0, 2'b10, 0, 0, 0, 0, 0, 0);

    // 6: hold coincident with door leaving; the hold count must be cleared.
    step(0, 2'b01, 0, 1, 0, 0, 0, 0);
    step(0, 2'b01, 0, 2, 0, 0, 0, 0);
    step(0, 2'b01, 1, 1, 0, 0, 0, 0);
    step(0, 2'b01, 0, 2, 0, 0, 0, 0);
    step(0, 2'b01, 0, 3, 0, 0, 0, 0);
    step(0, 2'b01, 0, 4, 0, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0, 0, 0, 0);
    step(0, 2'b01, 0, 1, 0, 0, 0, 0);
    step(0, 2'b01, 1, 1, 0, 0, 0, 0);
    step(0, 2'b01, 1, 1, 0, 0, 0, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
